// File: rtl/moore_seq_checker.sv
// Protocol monitor for the 2-bit Moore symbol stream: locks on 00, follows 00-01-(10)-11-00.
// One clock from sampling edge to every output; in_valid low freezes the checker.
module moore_seq_checker #(
  parameter int CNT_W      = 8,
  parameter bit ALLOW_HOLD = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [1:0]       sym,
  output logic             locked,
  output logic             cycle_done,
  output logic             bypass_seen,
  output logic             err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       exp_next
);

  typedef enum logic {HUNT, TRACK} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state, state_nxt;
  logic [1:0]       prev, prev_nxt;
  logic             skip, skip_nxt;
  logic             done_nxt, err_nxt, byp_nxt;
  logic [CNT_W-1:0] ccnt_nxt, ecnt_nxt;
  logic             hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HUNT;
      prev        <= 2'b00;
      skip        <= 1'b0;
      locked      <= 1'b0;
      cycle_done  <= 1'b0;
      bypass_seen <= 1'b0;
      err         <= 1'b0;
      cycle_cnt   <= '0;
      err_cnt     <= '0;
      exp_next    <= 2'b00;
    end else begin
      state       <= state_nxt;
      prev        <= prev_nxt;
      skip        <= skip_nxt;
      locked      <= (state_nxt == TRACK);
      cycle_done  <= done_nxt;
      bypass_seen <= byp_nxt;
      err         <= err_nxt;
      cycle_cnt   <= ccnt_nxt;
      err_cnt     <= ecnt_nxt;
      // Expected symbol is simply prev+1 mod 4 while tracking.
      exp_next    <= (state_nxt == TRACK) ? prev_nxt + 2'd1 : 2'b00;
    end
  end

  always_comb begin
    state_nxt = state;
    prev_nxt  = prev;
    skip_nxt  = skip;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    byp_nxt   = bypass_seen;
    ccnt_nxt  = cycle_cnt;
    ecnt_nxt  = err_cnt;
    hold      = ALLOW_HOLD && (sym == prev);

    if (in_valid) begin
      case (state)
        HUNT: begin
          if (sym == 2'b00) begin
            state_nxt = TRACK;
            prev_nxt  = 2'b00;
            skip_nxt  = 1'b0;
          end
        end
        default: begin
          if (!hold) begin
            case ({prev, sym})
              4'b00_01: prev_nxt = sym;
              4'b01_10: begin prev_nxt = sym; skip_nxt = 1'b0; end
              4'b01_11: begin prev_nxt = sym; skip_nxt = 1'b1; end
              4'b10_11: prev_nxt = sym;
              4'b11_00: begin
                prev_nxt = sym;
                skip_nxt = 1'b0;
                done_nxt = 1'b1;
                byp_nxt  = skip;
                if (cycle_cnt != CNT_MAX) ccnt_nxt = cycle_cnt + CNT_ONE;
              end
              default: begin
                err_nxt = 1'b1;
                if (err_cnt != CNT_MAX) ecnt_nxt = err_cnt + CNT_ONE;
                // A 00 is a valid cycle start, so resync in place instead of hunting.
                if (sym == 2'b00) begin
                  prev_nxt = 2'b00;
                  skip_nxt = 1'b0;
                end else begin
                  state_nxt = HUNT;
                end
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_moore_seq_checker.sv
// Directed bench for moore_seq_checker: default, hold-tolerant and 2-bit-counter instances share stimulus.
module tb_moore_seq_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [1:0] sym = 2'b00;

  logic       a_locked, a_done, a_byp, a_err;
  logic [7:0] a_ccnt, a_ecnt;
  logic [1:0] a_exp;
  logic       h_locked, h_done, h_byp, h_err;
  logic [7:0] h_ccnt, h_ecnt;
  logic [1:0] h_exp;
  logic       s_locked, s_done, s_byp, s_err;
  logic [1:0] s_ccnt, s_ecnt;
  logic [1:0] s_exp;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  moore_seq_checker #(.CNT_W(8), .ALLOW_HOLD(1'b0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .sym(sym),
    .locked(a_locked), .cycle_done(a_done), .bypass_seen(a_byp), .err(a_err),
    .cycle_cnt(a_ccnt), .err_cnt(a_ecnt), .exp_next(a_exp));

  moore_seq_checker #(.CNT_W(8), .ALLOW_HOLD(1'b1)) dut_hold (
    .clk(clk), .reset(reset), .in_valid(in_valid), .sym(sym),
    .locked(h_locked), .cycle_done(h_done), .bypass_seen(h_byp), .err(h_err),
    .cycle_cnt(h_ccnt), .err_cnt(h_ecnt), .exp_next(h_exp));

  moore_seq_checker #(.CNT_W(2), .ALLOW_HOLD(1'b0)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .sym(sym),
    .locked(s_locked), .cycle_done(s_done), .bypass_seen(s_byp), .err(s_err),
    .cycle_cnt(s_ccnt), .err_cnt(s_ecnt), .exp_next(s_exp));

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one clock with the given inputs; outputs are settled on return.
  task automatic step(input logic rst, input logic v, input logic [1:0] s);
    @(negedge clk);
    reset = rst; in_valid = v; sym = s;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] s);
    step(1'b0, 1'b1, s);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 2'b00);
    step(1'b1, 1'b1, 2'b00);
  endtask

  initial begin
    // Reset state (in_valid=1, sym=00 held during reset must not lock)
    do_reset();
    chk("rst_locked", a_locked, 0);
    chk("rst_done",   a_done,   0);
    chk("rst_byp",    a_byp,    0);
    chk("rst_err",    a_err,    0);
    chk("rst_ccnt",   a_ccnt,   0);
    chk("rst_ecnt",   a_ecnt,   0);
    chk("rst_exp",    a_exp,    0);

    // Normal cycle
    send(2'b00);
    chk("n_locked", a_locked, 1);
    chk("n_exp0",   a_exp,    1);
    send(2'b01);
    chk("n_exp1",   a_exp,    2);
    send(2'b10);
    chk("n_exp2",   a_exp,    3);
    send(2'b11);
    chk("n_done_early", a_done, 0);
    chk("n_exp3",   a_exp,    0);
    send(2'b00);
    chk("n_done",   a_done,   1);
    chk("n_ccnt",   a_ccnt,   1);
    chk("n_byp",    a_byp,    0);
    chk("n_ecnt",   a_ecnt,   0);

    // Bypass cycle followed by a normal one
    do_reset();
    send(2'b00); send(2'b01);
    send(2'b11);
    chk("b_exp_after_11", a_exp, 0);
    send(2'b00);
    chk("b_done",  a_done, 1);
    chk("b_byp",   a_byp,  1);
    chk("b_ccnt",  a_ccnt, 1);
    send(2'b01);
    chk("b_done_pulse", a_done, 0);
    chk("b_byp_held",   a_byp,  1);
    send(2'b10); send(2'b11); send(2'b00);
    chk("b2_byp",  a_byp,  0);
    chk("b2_ccnt", a_ccnt, 2);

    // Illegal 01->00 resyncs in place
    do_reset();
    send(2'b00); send(2'b01); send(2'b00);
    chk("r_err",    a_err,    1);
    chk("r_ecnt",   a_ecnt,   1);
    chk("r_locked", a_locked, 1);
    chk("r_done",   a_done,   0);
    chk("r_exp",    a_exp,    1);
    send(2'b01);
    chk("r_err_pulse", a_err, 0);
    send(2'b10); send(2'b11); send(2'b00);
    chk("r_ccnt",  a_ccnt, 1);
    chk("r_ecnt2", a_ecnt, 1);

    // Illegal 00->10 drops to HUNT, then relocks on 00
    do_reset();
    send(2'b00); send(2'b10);
    chk("h_err",    a_err,    1);
    chk("h_locked", a_locked, 0);
    chk("h_exp",    a_exp,    0);
    send(2'b11);
    chk("h_err_11", a_err,    0);
    send(2'b01);
    chk("h_err_01", a_err,    0);
    chk("h_ecnt",   a_ecnt,   1);
    send(2'b00);
    chk("h_relock", a_locked, 1);

    // Gaps and repeated symbol, both hold policies
    do_reset();
    send(2'b00);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'b11);
    chk("g_locked", a_locked, 1);
    chk("g_exp",    a_exp,    1);
    chk("g_err",    a_err,    0);
    send(2'b01);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'b00);
    chk("g_err2",   a_err,    0);
    chk("g_exp2",   a_exp,    2);
    send(2'b01);
    chk("hold0_err",    a_err,    1);
    chk("hold0_ecnt",   a_ecnt,   1);
    chk("hold0_locked", a_locked, 0);
    chk("hold1_err",    h_err,    0);
    chk("hold1_ecnt",   h_ecnt,   0);
    chk("hold1_locked", h_locked, 1);
    chk("hold1_exp",    h_exp,    2);

    // Saturation with 2-bit counters
    do_reset();
    send(2'b00);
    for (int c = 0; c < 5; c++) begin
      send(2'b01); send(2'b10); send(2'b11); send(2'b00);
    end
    chk("s_ccnt",      s_ccnt, 3);
    chk("s_done",      s_done, 1);
    chk("s_wide_ccnt", a_ccnt, 5);

    // Mid-cycle reset abandons the partial cycle
    send(2'b01);
    step(1'b1, 1'b1, 2'b10);
    chk("m_locked", s_locked, 0);
    chk("m_ccnt",   s_ccnt,   0);
    chk("m_ecnt",   s_ecnt,   0);
    chk("m_done",   s_done,   0);
    chk("m_err",    s_err,    0);
    chk("m_byp",    s_byp,    0);
    chk("m_exp",    s_exp,    0);
    chk("m_wide",   a_ccnt,   0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
